// File: rtl/avl_frame_reg_writer_pkg.sv
// Shared constants and helpers for the frame-synchronised Avalon register writer.
package avl_frame_reg_writer_pkg;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;

    // Control/status register address and bit positions inside it.
    localparam logic [3:0] CTRL_ADDR   = 4'hF;
    localparam int         COMMIT_BIT  = 0;
    localparam int         PENDING_BIT = 1;
    localparam int         FCNT_LSB    = 16;
    localparam int         FCNT_W      = 16;

    // Builds the read-back word of the control/status register.
    function automatic logic [31:0] status_word(input logic [FCNT_W-1:0] fcnt,
                                                input logic              pending);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[FCNT_LSB +: FCNT_W] = fcnt;
        w[PENDING_BIT]        = pending;
        return w;
    endfunction

endpackage

// File: rtl/avl_frame_reg_writer_frame_edge_detect.sv
// Rising-edge detector for a level that is already synchronous to CLK.
// The pulse is suppressed on the first cycle after reset release so that a
// level that is already high coming out of reset is not mistaken for an edge.
module frame_edge_detect (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_d;
    logic r_armed;

    // History of the level and the post-reset arming flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_level_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_level_d <= i_level;
            r_armed   <= 1'b1;
        end
    end

    // A rise is high now while it was low last cycle, once armed.
    always_comb begin
        o_rise = i_level & ~r_level_d & r_armed;
    end

endmodule

// File: rtl/avl_frame_reg_writer.sv
// Avalon-MM register bank with shadow/active double buffering. Software
// writes shadows and requests a commit; the copy to the active set happens on
// the next frame boundary so consumers never see a half-updated frame.
module avl_frame_reg_writer #(
    parameter int NUM_REGS = avl_frame_reg_writer_pkg::NUM_REGS,
    parameter int DATA_W   = avl_frame_reg_writer_pkg::DATA_W
) (
    input  logic                                    CLK,
    input  logic                                    RESET_N,
    input  logic                                    AVL_CS,
    input  logic                                    AVL_READ,
    input  logic                                    AVL_WRITE,
    input  logic [avl_frame_reg_writer_pkg::ADDR_W-1:0] AVL_ADDR,
    input  logic [DATA_W/8-1:0]                     AVL_BYTE_EN,
    input  logic [DATA_W-1:0]                       AVL_WRITEDATA,
    output logic [DATA_W-1:0]                       AVL_READDATA,
    input  logic                                    FRAME_START,
    output logic [(NUM_REGS-1)*DATA_W-1:0]          ACTIVE_REGS,
    output logic                                    COMMIT_PULSE
);

    import avl_frame_reg_writer_pkg::*;

    localparam int NSH   = NUM_REGS - 1;
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0]       r_shadow [NSH];
    logic [NSH*DATA_W-1:0]   r_active;
    logic                    r_pending;
    logic                    r_commit_pulse;
    logic [FCNT_W-1:0]       r_frame_cnt;
    logic [DATA_W-1:0]       r_readdata;

    logic                    w_frame_edge;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_commit_req;
    logic                    w_commit;
    logic [NSH-1:0]          w_sh_sel;
    logic [DATA_W-1:0]       w_sh_rd;
    logic [DATA_W-1:0]       w_rd_val;

    frame_edge_detect u_frame_edge (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_level (FRAME_START),
        .o_rise  (w_frame_edge)
    );

    // Bus decode: strobes, commit request and shadow write selects.
    always_comb begin
        w_wr         = AVL_CS & AVL_WRITE;
        w_rd         = AVL_CS & AVL_READ;
        w_commit_req = w_wr & (AVL_ADDR == CTRL_ADDR) & AVL_BYTE_EN[0]
                       & AVL_WRITEDATA[COMMIT_BIT];
        w_commit     = w_frame_edge & r_pending;
        w_sh_sel     = '0;
        for (int k = 0; k < NSH; k++) begin
            w_sh_sel[k] = w_wr & (AVL_ADDR == 4'(k));
        end
    end

    // Read mux; sees current (pre-write) register contents.
    always_comb begin
        w_sh_rd = '0;
        for (int k = 0; k < NSH; k++) begin
            w_sh_rd = w_sh_rd | (r_shadow[k] & {DATA_W{AVL_ADDR == 4'(k)}});
        end
        if (AVL_ADDR == CTRL_ADDR) begin
            w_rd_val = DATA_W'(status_word(r_frame_cnt, r_pending));
        end else begin
            w_rd_val = w_sh_rd;
        end
    end

    // Shadow registers: byte-lane masked writes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NSH; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSH; k++) begin
                for (int b = 0; b < LANES; b++) begin
                    if (w_sh_sel[k] && AVL_BYTE_EN[b]) begin
                        r_shadow[k][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    // Active copy on commit; shadows are sampled before any same-cycle write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_active       <= '0;
            r_commit_pulse <= 1'b0;
        end else begin
            r_commit_pulse <= w_commit;
            if (w_commit) begin
                for (int k = 0; k < NSH; k++) begin
                    r_active[k*DATA_W +: DATA_W] <= r_shadow[k];
                end
            end
        end
    end

    // Pending flag: a new request wins over the clear from a commit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending <= 1'b0;
        end else if (w_commit_req) begin
            r_pending <= 1'b1;
        end else if (w_commit) begin
            r_pending <= 1'b0;
        end
    end

    // Free-running frame counter, wraps naturally at 16 bits.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_frame_cnt <= '0;
        end else if (w_frame_edge) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Registered read data, held until the next read.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rd_val;
        end
    end

    assign AVL_READDATA = r_readdata;
    assign ACTIVE_REGS  = r_active;
    assign COMMIT_PULSE = r_commit_pulse;

endmodule

// File: doc/avl_frame_reg_writer.md
AVL_FRAME_REG_WRITER -- requirements
Module: avl_frame_reg_writer

Interface
REQ-001 The parameter NUM_REGS SHALL default to 16 and SHALL set the total register count, with index NUM_REGS-1 as control/status.
REQ-002 The parameter DATA_W SHALL default to 32 and SHALL set the register width.
REQ-003 CLK  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-005 AVL_CS  in  1  chip select; READ/WRITE are ignored while low.
REQ-006 AVL_READ  in  1  read request.
REQ-007 AVL_WRITE  in  1  write request.
REQ-008 AVL_ADDR  in  4  register index.
REQ-009 AVL_BYTE_EN  in  4  byte lane enables for writes.
REQ-010 AVL_WRITEDATA  in  32  write data.
REQ-011 AVL_READDATA  out  32  registered read data.
REQ-012 FRAME_START  in  1  frame-boundary level (VGA vsync-derived), synchronous to CLK.
REQ-013 ACTIVE_REGS  out  480  active copies of registers 0..14, register k at bits [32k+31:32k].
REQ-014 COMMIT_PULSE  out  1  one-cycle strobe on each completed commit.

Function
REQ-015 Registers 0..14 SHALL be shadow registers writable over Avalon; ACTIVE_REGS SHALL change only on commit.
REQ-016 A write (CS=1, WRITE=1) to addr 0..14 SHALL update only the byte lanes whose AVL_BYTE_EN bit is 1, in the next cycle.
REQ-017 A write to addr 15 with BYTE_EN[0]=1 and WRITEDATA[0]=1 SHALL set the pending flag; all other bits written to addr 15 SHALL be ignored.
REQ-018 Read latency SHALL be exactly 1 cycle: AVL_READDATA SHALL be valid the cycle after CS=1, READ=1, and SHALL hold until the next read.
REQ-019 A read of addr 0..14 SHALL return the shadow value; a read of addr 15 SHALL return {frame_count[15:0], 14'b0, pending, 1'b0}.
REQ-020 If READ and WRITE are both asserted to the same address, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-021 A frame edge SHALL be defined as FRAME_START 0->1 between consecutive cycles.
REQ-022 On each frame edge, frame_count SHALL increment and SHALL wrap from 0xFFFF to 0x0000.
REQ-023 On a frame edge with pending=1, all 15 shadows SHALL be copied to active, pending SHALL be cleared, and COMMIT_PULSE SHALL be high the following cycle only.
REQ-024 If a shadow write coincides with a committing edge, the pre-write shadow value SHALL be copied, and the new value SHALL remain in shadow only.
REQ-025 If a commit-request write coincides with an edge while pending=0, no copy SHALL occur and pending SHALL be 1 afterwards.
REQ-026 If a commit-request write coincides with a committing edge, the copy SHALL occur and pending SHALL remain 1.
REQ-027 A frame edge with pending=0 SHALL leave ACTIVE_REGS unchanged and keep COMMIT_PULSE at 0.

Reset
REQ-028 While RESET_N=0, all shadow and active registers, pending, frame_count, AVL_READDATA, COMMIT_PULSE, and the FRAME_START history flop SHALL be 0.
REQ-029 A reset asserted mid-operation SHALL discard any pending commit; the first cycle after release SHALL NOT detect a frame edge even if FRAME_START=1.

Structure
REQ-030 A shared package SHALL hold NUM_REGS, CTRL_ADDR=4'hF, bit indices COMMIT_BIT=0 and PENDING_BIT=1, and FCNT_LSB=16.
REQ-031 Frame-edge detection SHALL be a sub-module, frame_edge_detect (CLK, RESET_N, level in, one-cycle rise pulse out).

Verification
REQ-032 Write addr 3 = 0xDEADBEEF with BYTE_EN=0101, then read addr 3 -> 0x00AD00EF one cycle after READ; ACTIVE_REGS[127:96] still 0.
REQ-033 Write addr 0 = 0x12345678, write addr 15 = 0x1, then a FRAME_START edge -> active reg 0 = 0x12345678, COMMIT_PULSE high 1 cycle, addr 15 reads 0x00010000.
REQ-034 Write addr 2 = 0xAAAA0000 in the same cycle as a committing edge -> active reg 2 keeps its old value, and shadow reads 0xAAAA0000.
REQ-035 Apply 65536 frame edges with no commit -> frame_count wraps to 0, ACTIVE_REGS unchanged, and COMMIT_PULSE never asserted.
REQ-036 Set pending, then pulse RESET_N low for 1 cycle while FRAME_START=1 -> after release pending=0, no commit, and all outputs 0.
REQ-037 Hold CS=0 with WRITE=1 to addr 5 -> shadow 5 stays 0.
